layer_seq: RTL and testbench
============================

Name: layer_seq

Overview:
- Sequencer for one fully-connected MNIST layer built around the shared 2-stage multiply unit (8-bit unsigned feature × 8-bit signed weight → 16-bit signed product, `done` 2 cycles after `en`).
- For each of OUT_LEN neurons: streams IN_LEN feature/weight pairs from external synchronous RAMs into the multiplier and accumulates the products.
- Then adds the neuron bias, shifts, clamps and emits one 8-bit activation per neuron.
- Sits between the feature/weight/bias memories and the next layer's input buffer.

Parameters:
- IN_LEN, 784, inputs per neuron (≥1).
- OUT_LEN, 10, neurons per layer (≥1).
- ACC_W, 32, signed accumulator width.
- SHIFT, 8, arithmetic right shift applied after bias add (0..ACC_W-1).
- FA_W, 10, feature address width (≥clog2(IN_LEN)).
- WA_W, 14, weight address width (≥clog2(IN_LEN*OUT_LEN)).
- NA_W, 4, neuron index width (≥clog2(OUT_LEN)).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin layer; sampled in IDLE only.
- busy  out  1  high from the cycle after start is accepted until layer_done.
- mem_rd_en  out  1  read strobe to feature and weight RAMs.
- feat_addr  out  FA_W  feature RAM address = k.
- weight_addr  out  WA_W  weight RAM address = n*IN_LEN + k.
- bias_addr  out  NA_W  bias RAM address = n, held for the whole neuron.
- bias_data  in  16  signed bias, valid from the 2nd cycle of ISSUE for neuron n.
- mac_en  out  1  multiplier enable; registered copy of mem_rd_en, aligned with RAM data (RAM data returns 1 cycle after mem_rd_en).
- mac_result  in  16  signed product from the multiplier.
- mac_done  in  1  product valid strobe.
- out_data  out  8  activation.
- out_idx  out  NA_W  neuron index of out_data.
- out_valid  out  1  one-cycle pulse per neuron.
- layer_done  out  1  one-cycle pulse after the last neuron.

Behaviour:
- Reset: all outputs 0. State IDLE, counters k=n=0, acc=0, issued/received counts 0. Reset mid-layer aborts immediately; no out_valid or layer_done afterwards.
- States: IDLE, ISSUE, DRAIN, OUT, FIN.
- IDLE: on start=1 → ISSUE with n=0, k=0, acc=0, rcv=0.
- ISSUE: mem_rd_en=1 for exactly IN_LEN consecutive cycles, k=0..IN_LEN-1. After the cycle with k=IN_LEN-1 → DRAIN.
- Accumulation, all states: on mac_done, acc += sign-extend(mac_result) and rcv++.
- DRAIN: wait until rcv==IN_LEN, i.e. 3 cycles after the last issue, then → OUT.
  - Same-cycle done and transition: the final accumulate must be included.
- OUT, one cycle:
  - s = (acc + sign-extend(bias_data)) >>> SHIFT.
  - Clamp s per Optional Feature, then drive out_data/out_idx and pulse out_valid.
  - Then clear acc and rcv. If n==OUT_LEN-1 → FIN, else n++, k=0, → ISSUE.
- FIN: pulse layer_done for 1 cycle, busy drops the same cycle, → IDLE.
- start while busy is ignored. The accumulator is wide enough; no overflow handling beyond ACC_W wrap.
- Latency per neuron from first ISSUE cycle to out_valid: IN_LEN+4 cycles. Total layer = 1 + OUT_LEN*(IN_LEN+4) + 1 cycles from start to layer_done.
- mac_en is 0 whenever not streaming, including in OUT/FIN/IDLE.

Optional Feature:
- Macro LAYER_SEQ_RELU_EN.
- Defined (hidden layer): out_data = unsigned ReLU clamp; s<0→0, s>255→255, else s[7:0].
- Undefined (output logits): out_data = signed two's-complement saturation; s<-128→8'h80, s>127→8'h7F, else s[7:0].

Test Plan:
1. IN_LEN=4, OUT_LEN=2, SHIFT=0, features {1,1,1,1}, weights n0 {1,2,3,4} n1 {-1,-1,-1,-1}, bias {6,2}, RELU_EN on → out (idx0,16), (idx1,0); layer_done at cycle 1+2*8+1 after start.
2. Same stimulus with RELU_EN off → out (idx0,16), (idx1,8'hFE = -2).
3. Saturation, IN_LEN=4, SHIFT=8, features 255, weights 127, bias 0 → s=506 → out 255 (RELU_EN) or 127 (off); weights -128 → s=-510 → 0 or 8'h80.
4. Address/enable check: capture mem_rd_en, feat_addr, weight_addr each cycle → exactly IN_LEN strobes per neuron, weight_addr n*IN_LEN+k contiguous, mac_en equals mem_rd_en delayed 1.
5. start pulsed repeatedly during busy → ignored, exactly OUT_LEN out_valid and one layer_done.
6. rstn low during neuron 1's ISSUE → all outputs 0 immediately; new start after release produces a full correct layer from n=0.

Source files
------------

// File: rtl/layer_seq.sv
// layer_seq: fully-connected layer sequencer streaming feature/weight pairs into a shared 2-stage multiplier.
// Define LAYER_SEQ_RELU_EN for ReLU output clamping (hidden layer); default is signed saturation (logits).
module layer_seq #(
    parameter int IN_LEN  = 784,
    parameter int OUT_LEN = 10,
    parameter int ACC_W   = 32,
    parameter int SHIFT   = 8,
    parameter int FA_W    = 10,
    parameter int WA_W    = 14,
    parameter int NA_W    = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    output logic                     busy,
    output logic                     mem_rd_en,
    output logic [FA_W-1:0]          feat_addr,
    output logic [WA_W-1:0]          weight_addr,
    output logic [NA_W-1:0]          bias_addr,
    input  logic signed [15:0]       bias_data,
    output logic                     mac_en,
    input  logic signed [15:0]       mac_result,
    input  logic                     mac_done,
    output logic [7:0]               out_data,
    output logic [NA_W-1:0]          out_idx,
    output logic                     out_valid,
    output logic                     layer_done
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, FIN} state_t;
    state_t state, state_nx;
    logic [FA_W-1:0] k;
    logic [FA_W:0] rcv, rcv_nx;
    logic [NA_W-1:0] n;
    logic [WA_W-1:0] waddr;
    logic signed [ACC_W-1:0] acc, acc_nx, s;
    logic [7:0] act;
    logic last_k, last_n;

    assign last_k = k == FA_W'(IN_LEN - 1);
    assign last_n = n == NA_W'(OUT_LEN - 1);
    assign acc_nx = mac_done ? acc + ACC_W'(mac_result) : acc;
    assign rcv_nx = rcv + {{FA_W{1'b0}}, mac_done};
    assign s = (acc + ACC_W'(bias_data)) >>> SHIFT;
    assign feat_addr = k;
    assign weight_addr = waddr;
    assign bias_addr = n;

`ifdef LAYER_SEQ_RELU_EN
    assign act = s < 0 ? 8'd0 : (s > ACC_W'(255) ? 8'hFF : s[7:0]);
`else
    assign act = s < ACC_W'(-128) ? 8'h80 : (s > ACC_W'(127) ? 8'h7F : s[7:0]);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else state <= state_nx;
    end

    // DRAIN looks at the post-accumulate count so a done landing on the exit cycle is not lost
    always_comb begin
        state_nx = state;
        mem_rd_en = 1'b0;
        busy = state != IDLE;
        case (state)
            IDLE:    state_nx = start ? ISSUE : IDLE;
            ISSUE: begin
                mem_rd_en = 1'b1;
                state_nx = last_k ? DRAIN : ISSUE;
            end
            DRAIN:   state_nx = rcv_nx == (FA_W+1)'(IN_LEN) ? OUT : DRAIN;
            OUT:     state_nx = last_n ? FIN : ISSUE;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k <= '0;
            n <= '0;
            waddr <= '0;
            acc <= '0;
            rcv <= '0;
            mac_en <= 1'b0;
            out_data <= '0;
            out_idx <= '0;
            out_valid <= 1'b0;
            layer_done <= 1'b0;
        end else begin
            mac_en <= mem_rd_en;
            out_valid <= state == OUT;
            layer_done <= state == FIN;
            acc <= acc_nx;
            rcv <= rcv_nx;
            if (state == ISSUE) begin
                k <= k + 1'b1;
                waddr <= waddr + 1'b1;
            end
            if (state == IDLE && start) begin
                k <= '0;
                n <= '0;
                waddr <= '0;
                acc <= '0;
                rcv <= '0;
            end
            if (state == OUT) begin
                out_data <= act;
                out_idx <= n;
                acc <= '0;
                rcv <= '0;
                k <= '0;
                if (!last_n) n <= n + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: random and directed layers against an arithmetic dot-product model with a queued scoreboard.
module tb_layer_seq;
    localparam int IN_LEN = 4, OUT_LEN = 3, ACC_W = 32, SHIFT = 4;
    localparam int FA_W = 3, WA_W = 4, NA_W = 2;
    localparam int NC = IN_LEN + 4;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
    logic busy, mem_rd_en, mac_en, mac_done, out_valid, layer_done;
    logic [FA_W-1:0] feat_addr;
    logic [WA_W-1:0] weight_addr;
    logic [NA_W-1:0] bias_addr, out_idx;
    logic signed [15:0] bias_data, mac_result;
    logic [7:0] out_data;

    logic [7:0] feat_mem [IN_LEN];
    logic signed [7:0] w_mem [IN_LEN*OUT_LEN];
    logic signed [15:0] b_mem [OUT_LEN];
    logic [7:0] fd;
    logic signed [7:0] wd;
    logic signed [15:0] p1;
    logic v1;

    typedef struct {int idx; int data; int at;} exp_t;
    exp_t exp_q[$];
    exp_t e;
    int done_q[$];
    int cyc = 0, total = 0, bad = 0;
    int win_lo = 0, win_hi = 0, strobes = 0;
    logic prev_rd = 1'b0;

    layer_seq #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .ACC_W(ACC_W), .SHIFT(SHIFT),
                .FA_W(FA_W), .WA_W(WA_W), .NA_W(NA_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .mem_rd_en(mem_rd_en),
        .feat_addr(feat_addr), .weight_addr(weight_addr), .bias_addr(bias_addr),
        .bias_data(bias_data), .mac_en(mac_en), .mac_result(mac_result), .mac_done(mac_done),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .layer_done(layer_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous RAMs and the 2-stage multiplier the sequencer drives
    always @(posedge clk) begin
        if (mem_rd_en) begin
            fd <= feat_mem[feat_addr];
            wd <= w_mem[weight_addr];
        end
        bias_data <= b_mem[bias_addr];
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1 <= 1'b0;
            p1 <= '0;
            mac_done <= 1'b0;
            mac_result <= '0;
        end else begin
            v1 <= mac_en;
            p1 <= 16'($signed({1'b0, fd}) * wd);
            mac_done <= v1;
            mac_result <= p1;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic int clamp(input int s);
`ifdef LAYER_SEQ_RELU_EN
        return s < 0 ? 0 : (s > 255 ? 255 : s);
`else
        return s < -128 ? 128 : (s > 127 ? 127 : (s & 255));
`endif
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            strobes = 0;
            prev_rd = 1'b0;
        end else begin
            chk("mac_en", int'(mac_en), int'(prev_rd));
            prev_rd = mem_rd_en;
            chk("busy", int'(busy), int'(cyc >= win_lo && cyc < win_hi));
            if (mem_rd_en) begin
                chk("feat_addr", int'(feat_addr), strobes % IN_LEN);
                chk("weight_addr", int'(weight_addr), strobes);
                chk("bias_addr", int'(bias_addr), strobes / IN_LEN);
                strobes++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected out_valid queue", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("out_idx", int'(out_idx), e.idx);
                    chk("out_data", int'(out_data), e.data);
                    chk("out_cycle", cyc, e.at);
                end
            end
            if (layer_done) begin
                if (done_q.size() == 0) chk("unexpected layer_done queue", done_q.size(), 1);
                else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                    chk("strobe_count", strobes, IN_LEN * OUT_LEN);
                    chk("outputs_pending", exp_q.size(), 0);
                end
                strobes = 0;
            end
        end
    end

    task automatic fill(input int mode);
        for (int i = 0; i < IN_LEN; i++)
            feat_mem[i] = mode == 0 ? 8'd16 : (mode < 3 ? 8'd255 : (mode == 3 ? 8'($urandom_range(0, 15)) : 8'($urandom)));
        for (int i = 0; i < IN_LEN * OUT_LEN; i++) begin
            case (mode)
                0: w_mem[i] = i < IN_LEN ? 8'(i + 1) : (i < 2 * IN_LEN ? -8'sd1 : 8'(i % 5) - 8'sd2);
                1: w_mem[i] = 8'sd127;
                2: w_mem[i] = -8'sd128;
                3: w_mem[i] = 8'($urandom_range(0, 15) - 8);
                default: w_mem[i] = 8'($urandom);
            endcase
        end
        for (int j = 0; j < OUT_LEN; j++)
            b_mem[j] = mode == 0 ? 16'(j == 0 ? 6 : (j == 1 ? 2 : -100)) : (mode < 3 ? 16'sd0 :
                       (mode == 3 ? 16'($urandom_range(0, 127) - 64) : 16'($urandom)));
    endtask

    task automatic run_layer(input int mode, input bit abort, input bit noise);
        int sum, c0, cnt;
        exp_t x;
        fill(mode);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c0 = cyc;
        for (int j = 0; j < OUT_LEN; j++) begin
            sum = int'(b_mem[j]);
            for (int i = 0; i < IN_LEN; i++) sum += int'(feat_mem[i]) * int'(w_mem[j * IN_LEN + i]);
            x.idx = j;
            x.data = clamp(sum >>> SHIFT);
            x.at = c0 + (j + 1) * NC;
            exp_q.push_back(x);
        end
        win_lo = c0;
        win_hi = c0 + OUT_LEN * NC + 1;
        done_q.push_back(win_hi);
        if (abort) begin
            while (cyc < c0 + NC + 2) @(negedge clk);
            #2 rstn = 1'b0;
            #1;
            chk("rst busy", int'(busy), 0);
            chk("rst mem_rd_en", int'(mem_rd_en), 0);
            chk("rst mac_en", int'(mac_en), 0);
            chk("rst feat_addr", int'(feat_addr), 0);
            chk("rst weight_addr", int'(weight_addr), 0);
            chk("rst bias_addr", int'(bias_addr), 0);
            chk("rst out_data", int'(out_data), 0);
            chk("rst out_idx", int'(out_idx), 0);
            chk("rst out_valid", int'(out_valid), 0);
            chk("rst layer_done", int'(layer_done), 0);
            exp_q.delete();
            done_q.delete();
            win_hi = 0;
            repeat (3) @(negedge clk);
            rstn = 1'b1;
            repeat (NC) @(negedge clk);
        end else begin
            cnt = 0;
            while (cnt < OUT_LEN * NC + 5) begin
                @(negedge clk);
                cnt++;
                if (layer_done) break;
                start = noise && $urandom_range(0, 2) == 0;
            end
            start = 1'b0;
            chk("layer_done seen", int'(layer_done), 1);
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("init busy", int'(busy), 0);
        chk("init mem_rd_en", int'(mem_rd_en), 0);
        chk("init out_valid", int'(out_valid), 0);
        chk("init layer_done", int'(layer_done), 0);
        rstn = 1'b1;
        @(negedge clk);
        run_layer(0, 1'b0, 1'b0);
        run_layer(1, 1'b0, 1'b1);
        run_layer(2, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) run_layer(3, 1'b0, i[0]);
        run_layer(4, 1'b0, 1'b1);
        run_layer(4, 1'b0, 1'b0);
        run_layer(3, 1'b1, 1'b0);
        run_layer(0, 1'b0, 1'b1);
        run_layer(3, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("leftover outputs", exp_q.size(), 0);
        chk("leftover layer_done", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
